decoder_scan_ctrl: RTL
======================

Name: decoder_scan_ctrl

Overview:
Upstream sequencer for the 2-to-4 decoder. It drives the decoder's select bus A[1:0] and enable E. It steps through the four decoder outputs in order, skipping masked slots, and holds each slot active for a programmable dwell time. A fixed blanking gap keeps E low while A changes, so two decoder outputs are never high during a transition. Typical uses are display-digit and row multiplexing, with either continuous or single-sweep operation.

Parameters:
DWELL_W, 8, width of the dwell input and of the internal dwell counter.
BLANK_CYC, 2, number of cycles E is held low after each A change. Legal range is 1 to 15.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
en  input  1  run request, level-sensitive.
mode  input  1  0 = continuous sweep, 1 = single sweep then stop.
dwell  input  DWELL_W  E-high cycles per slot. A value of 0 is treated as 1.
mask  input  4  slot enables. mask[i]=1 means slot i is visited.
A  output  2  decoder select, registered.
E  output  1  decoder enable, registered.
busy  output  1  high whenever the FSM is not in IDLE.
sweep_done  output  1  one-cycle pulse when a sweep completes.

Behaviour:
- Reset (rst_n=0, asynchronous): A=0, E=0, busy=0, sweep_done=0, state=IDLE, counters=0. Outputs go low immediately, without waiting for a clock edge.
- All outputs are registered. No combinational path exists from inputs to outputs.
- States: IDLE, BLANK, ACTIVE.
- IDLE:
  - E=0; A holds its last value.
  - On an edge with en=1 and mask!=0: go to BLANK, load A with the lowest set bit of mask, and load the blank counter.
  - If en=1 and mask==0: stay in IDLE.
- BLANK:
  - E=0 for exactly BLANK_CYC cycles.
  - At the end of the gap: go to ACTIVE, set E=1, and load the dwell counter from max(dwell,1). dwell is sampled only at this edge.
- ACTIVE:
  - E=1 for exactly max(dwell,1) cycles.
  - At the end of the dwell, on the same edge: set E=0 and choose the next slot.
- Next-slot selection:
  - Use the lowest set mask bit strictly above the current A. If none exists, wrap to the lowest set mask bit.
  - mask is sampled only at this edge.
- Sweep completion:
  - A sweep is complete when the slot being left is the highest set bit of mask (as sampled at that edge).
  - sweep_done=1 for that one cycle.
  - If mode=1, go to IDLE with A held. Otherwise go to BLANK with the new A.
- mask sampled as 0 at a selection edge: go to IDLE with no sweep_done.
- en=0 in BLANK or ACTIVE: on the next edge go to IDLE, E=0, A held, no sweep_done. A later en=1 restarts from the lowest enabled slot.
- Simultaneous events at the same edge:
  - en=0 has priority over the end of dwell, so sweep_done is suppressed.
  - Within a single slot, mode changes take effect at the next sweep-completion check.
- Steady-state period per slot is BLANK_CYC + max(dwell,1) cycles.
- A changes only on edges where E goes or stays 0. E is never 1 on the cycle that A changes.
- busy=1 in BLANK and ACTIVE, 0 in IDLE.

Test Plan:
1. Continuous sweep: BLANK_CYC=2, dwell=3, mask=4'b1111, mode=0, en=1.
   - A sequence is 0,1,2,3,0,…
   - E pattern per slot is 0,0,1,1,1.
   - sweep_done pulses once every 20 cycles, on the edge that leaves A=3.
2. Masked slots: mask=4'b1010, dwell=1.
   - A alternates 1,3,1,…; slots 0 and 2 are never selected.
   - sweep_done pulses each time A=3 is left, i.e. every 6 cycles.
3. Single sweep: mode=1, mask=4'b0110, dwell=2.
   - A visits 1 then 2.
   - sweep_done is 1 for one cycle; busy then goes 0 and E stays 0 with A held at 2.
4. Abort and reset:
   - Deassert en during the 2nd ACTIVE cycle: E=0 on the next edge, state IDLE, no sweep_done.
   - Later, assert rst_n=0 mid-ACTIVE: A=0, E=0, busy=0 immediately, before any clock edge.
5. Boundary values:
   - dwell=0 gives E high for exactly 1 cycle per slot.
   - dwell=255 gives exactly 255 cycles.
   - mask=0 with en=1 keeps busy=0, E=0 indefinitely.
6. Overlap check: across 1000 random mask/dwell/en cycles, A never changes while E=1, and E is never 1 on the same cycle A changes.

Source files
------------

// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer for a 2-to-4 decoder: steps A through the enabled slots, holds E
// high for a programmable dwell and keeps E low for a fixed blanking gap around A changes.
module decoder_scan_ctrl #(
  parameter int DWELL_W   = 8,
  parameter int BLANK_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [3:0]         mask,
  output logic [1:0]         A,
  output logic               E,
  output logic               busy,
  output logic               sweep_done
);

  typedef enum logic [1:0] {IDLE, BLANK, ACTIVE} state_t;

  localparam int                BCNT_W     = 4;
  localparam logic [BCNT_W-1:0] BLANK_LOAD = BCNT_W'(BLANK_CYC - 1);
  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

  state_t             state_q, state_d;
  logic [1:0]         a_q, a_d;
  logic               e_q, e_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BCNT_W-1:0]  blank_q, blank_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;

  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    lowest_set = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) lowest_set = 2'(i);
    end
  endfunction

  function automatic logic [1:0] highest_set(input logic [3:0] m);
    highest_set = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) highest_set = 2'(i);
    end
  endfunction

  // Lowest enabled slot strictly above cur, wrapping to the lowest enabled slot.
  function automatic logic [1:0] next_slot(input logic [3:0] m, input logic [1:0] cur);
    logic found;
    found     = 1'b0;
    next_slot = lowest_set(m);
    for (int i = 0; i < 4; i++) begin
      if (!found && m[i] && (2'(i) > cur)) begin
        next_slot = 2'(i);
        found     = 1'b1;
      end
    end
  endfunction

  // The dwell counter counts down to zero, so a load of max(dwell,1)-1 gives max(dwell,1) cycles.
  function automatic logic [DWELL_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
    dwell_load = (d == '0) ? '0 : d - DWELL_ONE;
  endfunction

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    e_d     = 1'b0;
    done_d  = 1'b0;
    blank_d = blank_q;
    dwell_d = dwell_q;
    case (state_q)
      IDLE: begin
        if (en && (mask != 4'd0)) begin
          state_d = BLANK;
          a_d     = lowest_set(mask);
          blank_d = BLANK_LOAD;
        end
      end
      BLANK: begin
        if (!en) begin
          state_d = IDLE;
        end else if (blank_q == '0) begin
          state_d = ACTIVE;
          e_d     = 1'b1;
          dwell_d = dwell_load(dwell);
        end else begin
          blank_d = blank_q - BCNT_W'(1);
        end
      end
      ACTIVE: begin
        if (!en) begin
          state_d = IDLE;
        end else if (dwell_q != '0) begin
          e_d     = 1'b1;
          dwell_d = dwell_q - DWELL_ONE;
        end else if (mask == 4'd0) begin
          state_d = IDLE;
        end else begin
          done_d = (a_q == highest_set(mask));
          if (done_d && mode) begin
            state_d = IDLE;
          end else begin
            state_d = BLANK;
            a_d     = next_slot(mask, a_q);
            blank_d = BLANK_LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= 2'd0;
      e_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      blank_q <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      e_q     <= e_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      blank_q <= blank_d;
      dwell_q <= dwell_d;
    end
  end

  assign A          = a_q;
  assign E          = e_q;
  assign busy       = busy_q;
  assign sweep_done = done_q;

endmodule
